// File: rtl/alu_seq_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   alu_op_t    - 4-bit operation codes; any code not listed is undefined
//   alu_state_t - control FSM states
//   alu_flags_t - packed NZCV flag group
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_LSL    = 4'b0011,
        OP_LSR    = 4'b0100,
        OP_SUB    = 4'b0110,
        OP_PASS_B = 4'b0111,
        OP_MUL    = 4'b1000,
        OP_NOR    = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result handshake bundle for alu_seq.
//   issue : in_valid, in_ready, a, b, op
//   result: out_valid, out_ready, result, zero, negative, carry, overflow
//   master = issuer/consumer side, slave = ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_t          op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow
    );

endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative unsigned shift-add multiplier, one bit of b per clock,
// LSB first. Bit 0 is consumed on the start edge, bits 1..WIDTH-1 on the
// following WIDTH-1 edges; done rises after the last one and stays high until
// the next start. product is the low WIDTH bits of a*b.
//   clk, reset     : clock, synchronous active-high reset (clears all state)
//   start, a, b    : load operands (a, b sampled on the start edge)
//   busy, done     : iterating / product ready
//   product        : accumulated result
module alu_seq_mul #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            count  <= CW'(1);
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and NZCV flags.
// Single-cycle ops are evaluated straight from the bus on the accept edge and
// land in the output registers (out_valid the next cycle). MUL hands the
// operands to the iterative multiplier and holds in_ready low until the
// product is loaded WIDTH+1 clocks after accept.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_seq_if slave (issue and result handshakes)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam int MSB = WIDTH - 1;
    localparam int SHW = $clog2(WIDTH);

    alu_state_t state_q, state_d;
    logic       in_ready;
    logic       start, ld_alu, ld_mul;
    logic       mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] res_q;
    alu_flags_t       flags_q;

    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] alu_res;
    alu_flags_t       alu_flags;

    assign in_ready = (state_q == IDLE) && !reset;

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        sum = {1'b0, bus.a} + {1'b0, bus.b};
        // carry out of a + ~b + 1 is the ARM "not borrow"
        dif = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        case (bus.op)
            OP_AND:    alu_res = bus.a & bus.b;
            OP_OR:     alu_res = bus.a | bus.b;
            OP_NOR:    alu_res = ~(bus.a | bus.b);
            OP_PASS_B: alu_res = bus.b;
            OP_LSL:    alu_res = bus.a << bus.b[SHW-1:0];
            OP_LSR:    alu_res = bus.a >> bus.b[SHW-1:0];
            OP_ADD: begin
                alu_res     = sum[MSB:0];
                alu_flags.c = sum[WIDTH];
                alu_flags.v = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_res     = dif[MSB:0];
                alu_flags.c = dif[WIDTH];
                alu_flags.v = (bus.a[MSB] != bus.b[MSB]) && (dif[MSB] != bus.a[MSB]);
            end
            // MUL arrives here only when the multiplier is absent: undefined
            default:   alu_res = '0;
        endcase
        alu_flags.n = alu_res[MSB];
        alu_flags.z = (alu_res == '0);
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        ld_alu  = 1'b0;
        ld_mul  = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid && in_ready) begin
                if (MUL_EN && bus.op == OP_MUL) begin
                    start   = 1'b1;
                    state_d = MUL;
                end else begin
                    ld_alu  = 1'b1;
                    state_d = DONE;
                end
            end
            MUL: if (mul_done && !mul_busy) begin
                ld_mul  = 1'b1;
                state_d = DONE;
            end
            DONE: if (bus.out_ready)
                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (ld_alu) begin
                res_q   <= alu_res;
                flags_q <= alu_flags;
            end else if (ld_mul) begin
                res_q   <= mul_product;
                flags_q <= '{n: mul_product[MSB], z: (mul_product == '0), c: 1'b0, v: 1'b0};
            end
        end
    end

    // ---------------- multiplier ----------------
    generate
        if (MUL_EN) begin : g_mul
            alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (start),
                .a       (bus.a),
                .b       (bus.b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.negative  = flags_q.n;
    assign bus.zero      = flags_q.z;
    assign bus.carry     = flags_q.c;
    assign bus.overflow  = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=64, MUL_EN=1): directed corner cases
// followed by randomized operations compared against an arithmetic model.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] r;
        logic [3:0]  nzcv;
    } mres_t;

    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.WIDTH(64)) bus ();

    alu_seq #(.WIDTH(64), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    // Reference model: plain arithmetic on the operation definitions.
    function automatic mres_t model(input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        mres_t m;
        logic [127:0] wide;
        logic signed [65:0] s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_AND:    m.r = a & b;
            OP_OR:     m.r = a | b;
            OP_NOR:    m.r = ~(a | b);
            OP_PASS_B: m.r = b;
            OP_LSL:    m.r = a << (b % 64);
            OP_LSR:    m.r = a >> (b % 64);
            OP_ADD: begin
                wide = {64'd0, a} + {64'd0, b};
                m.r  = wide[63:0];
                c    = wide[64];
                s    = 66'($signed(a)) + 66'($signed(b));
                v    = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                m.r = a - b;
                c   = (a >= b);
                s   = 66'($signed(a)) - 66'($signed(b));
                v   = (s > SMAX) || (s < SMIN);
            end
            OP_MUL: begin
                wide = {64'd0, a} * {64'd0, b};
                m.r  = wide[63:0];
            end
            default: m.r = 64'd0;
        endcase
        m.nzcv = {m.r[63], (m.r == 64'd0), c, v};
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] flags_now();
        return 64'({bus.negative, bus.zero, bus.carry, bus.overflow});
    endfunction

    // Issue one op, wait for the result, check it, hold backpressure for
    // 'hold' cycles, then release while offering a junk op that must be refused.
    task automatic run_op(input string tag, input alu_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        mres_t m;
        int    lat;
        logic  rdy_seen;
        m = model(op, a, b);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        check({tag, "_accept_rdy"}, 64'(bus.in_ready), 64'd1);
        tick();
        lat      = 1;
        rdy_seen = 1'b0;
        bus.a    = {$urandom, $urandom};
        bus.b    = {$urandom, $urandom};
        bus.op   = OP_ADD;
        while (!bus.out_valid && lat < 200) begin
            rdy_seen |= bus.in_ready;
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 64'(lat), (op == OP_MUL) ? 64'd65 : 64'd1);
        check({tag, "_busy_rdy"}, 64'(rdy_seen), 64'd0);
        check({tag, "_result"}, bus.result, m.r);
        check({tag, "_nzcv"}, flags_now(), 64'(m.nzcv));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_hold_result"}, bus.result, m.r);
            check({tag, "_hold_nzcv"}, flags_now(), 64'(m.nzcv));
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = OP_PASS_B;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_release_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_release_rdy"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic expect_last(input string tag, input logic [63:0] r, input logic [3:0] nzcv);
        check({tag, "_const_result"}, bus.result, r);
        check({tag, "_const_nzcv"}, flags_now(), 64'(nzcv));
    endtask

    initial begin
        int codes [12];
        logic seen_valid;
        logic [63:0] ra, rb;
        codes = '{0, 1, 2, 3, 4, 6, 7, 12, 8, 5, 15, 9};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_AND;

        // reset state
        repeat (3) tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_flags", flags_now(), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);

        // directed corners
        run_op("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        expect_last("add_ovf", 64'h8000_0000_0000_0000, 4'b1001);
        run_op("sub_eq", OP_SUB, 64'd5, 64'd5, 0);
        expect_last("sub_eq", 64'd0, 4'b0110);
        run_op("sub_borrow", OP_SUB, 64'd0, 64'd1, 1);
        expect_last("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
        run_op("mul_3x7", OP_MUL, 64'd3, 64'd7, 0);
        expect_last("mul_3x7", 64'd21, 4'b0000);
        run_op("mul_wrap", OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 0);
        expect_last("mul_wrap", 64'd0, 4'b0100);
        run_op("bp_add", OP_ADD, 64'h1234, 64'h4321, 3);
        expect_last("bp_add", 64'h5555, 4'b0000);
        run_op("lsl", OP_LSL, 64'd1, 64'd65, 0);
        expect_last("lsl", 64'd2, 4'b0000);
        run_op("lsr", OP_LSR, 64'h8000_0000_0000_0000, 64'd63, 0);
        expect_last("lsr", 64'd1, 4'b0000);
        run_op("undef", alu_op_t'(4'b1111), 64'hDEAD, 64'hBEEF, 0);
        expect_last("undef", 64'd0, 4'b0100);

        // reset 10 cycles into a MUL: the op must vanish
        bus.op       = OP_MUL;
        bus.a        = 64'd9;
        bus.b        = 64'd9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("midrst_in_ready_hi", 64'(bus.in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("midrst_ready", 64'(bus.in_ready), 64'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            seen_valid |= bus.out_valid;
            tick();
        end
        check("midrst_no_valid", 64'(seen_valid), 64'd0);
        run_op("or_after_rst", OP_OR, 64'hA, 64'h5, 0);
        expect_last("or_after_rst", 64'hF, 4'b0000);

        // randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: begin ra = ra & 64'hFF; rb = rb & 64'hFF; end
                1: rb = ra;
                2: begin ra[63] = 1'b0; rb[63] = 1'b1; end
                default: ;
            endcase
            run_op("rand", alu_op_t'(4'(codes[$urandom_range(0, 11)])), ra, rb,
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
